// File: rtl/rb_access_ctrl.sv
// Register-bank initiator: buffers writebacks in a FIFO, arbitrates operand reads against the drain.
// Optional RB_BYPASS_EN: reads always win in IDLE and forward the youngest matching FIFO entry.
module rb_access_ctrl #(
    parameter int unsigned DW         = 16,
    parameter int unsigned AW         = 4,
    parameter int unsigned WB_DEPTH   = 4,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [AW-1:0]     rd_ra,
    input  logic [AW-1:0]     rd_rb,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DW-1:0]     op_a,
    output logic [DW-1:0]     op_b,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [AW-1:0]     wb_rd,
    input  logic [DW-1:0]     wb_data,
    input  logic [DW-1:0]     rb_a,
    input  logic [DW-1:0]     rb_b,
    output logic [DW-1:0]     rb_d,
    output logic              rb_rw,
    output logic [3*AW-1:0]   rb_rs
);

    localparam int unsigned PW = $clog2(WB_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic {IDLE, RESP} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   fifo_rd_q   [WB_DEPTH];
    logic [DW-1:0]   fifo_data_q [WB_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [DW-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
    logic            full, empty, push, pop;
    logic            rd_issue, wr_issue;
    logic [DW-1:0]   fwd_a, fwd_b;

    assign full     = (count_q == CW'(WB_DEPTH));
    assign empty    = (count_q == '0);
    assign wb_ready = !full;
    assign push     = wb_valid && !full;
    assign pop      = wr_issue;

`ifdef RB_BYPASS_EN
    logic [PW-1:0] fwd_idx;

    // Walk oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_a   = rb_a;
        fwd_b   = rb_b;
        fwd_idx = '0;
        for (int unsigned i = 0; i < WB_DEPTH; i++) begin
            fwd_idx = rd_ptr_q + PW'(i);
            if (CW'(i) < count_q) begin
                if (fifo_rd_q[fwd_idx] == rd_ra) fwd_a = fifo_data_q[fwd_idx];
                if (fifo_rd_q[fwd_idx] == rd_rb) fwd_b = fifo_data_q[fwd_idx];
            end
        end
    end

    assign rd_issue = !rst && (state_q == IDLE) && rd_valid;
`else
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_q, starve_d;
    logic [PW-1:0] haz_idx;
    logic          hazard;

    always_comb begin
        hazard  = 1'b0;
        haz_idx = '0;
        for (int unsigned i = 0; i < WB_DEPTH; i++) begin
            haz_idx = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) &&
                ((fifo_rd_q[haz_idx] == rd_ra) || (fifo_rd_q[haz_idx] == rd_rb)))
                hazard = 1'b1;
        end
    end

    assign fwd_a = rb_a;
    assign fwd_b = rb_b;
    assign rd_issue = !rst && (state_q == IDLE) && rd_valid &&
                      (empty || ((starve_q == SW'(STARVE_MAX)) && !hazard));

    always_comb begin
        starve_d = starve_q;
        if (rd_issue)
            starve_d = '0;
        else if ((state_q == IDLE) && rd_valid && wr_issue && (starve_q != SW'(STARVE_MAX)))
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) starve_q <= '0;
        else     starve_q <= starve_d;
    end
`endif

    assign wr_issue = !rst && !empty && !rd_issue;
    assign count_d  = count_q + CW'(push) - CW'(pop);

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= wb_rd;
            fifo_data_q[wr_ptr_q] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_comb begin
        rb_rw = wr_issue;
        rb_d  = '0;
        rb_rs = '0;
        if (wr_issue) begin
            rb_d  = fifo_data_q[rd_ptr_q];
            rb_rs = {fifo_rd_q[rd_ptr_q], {(2*AW){1'b0}}};
        end else if (rd_issue) begin
            rb_rs = {{AW{1'b0}}, rd_ra, rd_rb};
        end
    end

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        case (state_q)
            IDLE: begin
                if (rd_issue) begin
                    state_d = RESP;
                    op_a_d  = fwd_a;
                    op_b_d  = fwd_b;
                end
            end
            RESP: begin
                if (op_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
        end
    end

    assign rd_ready = rd_issue;
    assign op_valid = (state_q == RESP);
    assign op_a     = op_a_q;
    assign op_b     = op_b_q;

endmodule

// File: tb/tb_rb_access_ctrl.sv
// Self-checking bench for rb_access_ctrl: register-bank model, queue-based reference, vector table.
// Honours RB_BYPASS_EN when defined for the build.
module tb_rb_access_ctrl;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int DEPTH = 4;
    localparam int SMAX = 4;

    logic          clk, rst;
    logic          rd_valid, rd_ready, op_valid, op_ready, wb_valid, wb_ready, rb_rw;
    logic [AW-1:0] rd_ra, rd_rb, wb_rd;
    logic [DW-1:0] op_a, op_b, wb_data, rb_a, rb_b, rb_d;
    logic [3*AW-1:0] rb_rs;

    rb_access_ctrl #(.DW(DW), .AW(AW), .WB_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_ra(rd_ra), .rd_rb(rd_rb),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .rb_a(rb_a), .rb_b(rb_b), .rb_d(rb_d), .rb_rw(rb_rw), .rb_rs(rb_rs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The register bank the controller talks to.
    logic [DW-1:0] rbmem [16];
    assign rb_a = rbmem[rb_rs[2*AW-1:AW]];
    assign rb_b = rbmem[rb_rs[AW-1:0]];
    always @(posedge clk) if (rb_rw) rbmem[rb_rs[3*AW-1:2*AW]] <= rb_d;

    // Reference model state.
    typedef struct { logic [AW-1:0] rd; logic [DW-1:0] data; } wb_t;
    wb_t           wq[$];
    logic [DW-1:0] mregs [16];
    bit            busy;
    int            starve;
    logic [DW-1:0] ea, eb;

    int checks, errors;
    bit last_rd_ready;

    typedef struct {
        logic wbv; logic [AW-1:0] wrd; logic [DW-1:0] wd;
        logic rdv; logic [AW-1:0] ra, rb; logic opr;
        logic e_rdy, e_wbr, e_rw; logic [3*AW-1:0] e_rs; logic [DW-1:0] e_d;
        logic e_opv; logic [DW-1:0] e_opa;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step(input bit use_vec, input vec_t v);
        bit hazard, rdi, wri, full0;
        logic [3*AW-1:0] ers;
        logic [DW-1:0] a, b;
        #1;
        if (rst) begin
            wq.delete(); busy = 0; starve = 0; ea = '0; eb = '0;
        end
        hazard = 0;
        foreach (wq[k]) if (wq[k].rd == rd_ra || wq[k].rd == rd_rb) hazard = 1;
`ifdef RB_BYPASS_EN
        rdi = !rst && !busy && rd_valid;
`else
        rdi = !rst && !busy && rd_valid && (wq.size() == 0 || (starve == SMAX && !hazard));
`endif
        wri   = !rst && wq.size() > 0 && !rdi;
        full0 = (wq.size() == DEPTH);
        ers   = '0;
        if (wri)      ers = {wq[0].rd, {(2*AW){1'b0}}};
        else if (rdi) ers = {{AW{1'b0}}, rd_ra, rd_rb};

        chk("rd_ready", 32'(rd_ready), 32'(rdi));
        chk("wb_ready", 32'(wb_ready), 32'(!full0));
        chk("rb_rw",    32'(rb_rw),    32'(wri));
        chk("rb_rs",    32'(rb_rs),    32'(ers));
        chk("rb_d",     32'(rb_d),     wri ? 32'(wq[0].data) : 32'h0);
        chk("op_valid", 32'(op_valid), 32'(busy));
        chk("op_a",     32'(op_a),     32'(ea));
        chk("op_b",     32'(op_b),     32'(eb));
        if (use_vec) begin
            chk("vec_rd_ready", 32'(rd_ready), 32'(v.e_rdy));
            chk("vec_wb_ready", 32'(wb_ready), 32'(v.e_wbr));
            chk("vec_rb_rw",    32'(rb_rw),    32'(v.e_rw));
            chk("vec_rb_rs",    32'(rb_rs),    32'(v.e_rs));
            chk("vec_rb_d",     32'(rb_d),     32'(v.e_d));
            chk("vec_op_valid", 32'(op_valid), 32'(v.e_opv));
            chk("vec_op_a",     32'(op_a),     32'(v.e_opa));
        end
        last_rd_ready = rd_ready;

        if (!rst) begin
            if (rdi) begin
                a = mregs[rd_ra];
                b = mregs[rd_rb];
`ifdef RB_BYPASS_EN
                foreach (wq[k]) begin
                    if (wq[k].rd == rd_ra) a = wq[k].data;
                    if (wq[k].rd == rd_rb) b = wq[k].data;
                end
`endif
                busy = 1; starve = 0; ea = a; eb = b;
            end else begin
                if (!busy && rd_valid && wri && starve < SMAX) starve++;
                if (busy && op_ready) busy = 0;
            end
            if (wri) begin
                mregs[wq[0].rd] = wq[0].data;
                void'(wq.pop_front());
            end
            if (wb_valid && !full0) wq.push_back('{rd: wb_rd, data: wb_data});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cyc();
        vec_t dummy;
        dummy = '{default: '0};
        step(0, dummy);
    endtask

    task automatic rand_cycles(input int n, input int pwb, input int prd, input int popr,
                               input int wmin, input int wmax, input int rmax);
        for (int i = 0; i < n; i++) begin
            wb_valid = ($urandom_range(0, 99) < pwb);
            wb_rd    = AW'($urandom_range(wmin, wmax));
            wb_data  = DW'($urandom);
            rd_valid = ($urandom_range(0, 99) < prd);
            rd_ra    = AW'($urandom_range(0, rmax));
            rd_rb    = AW'($urandom_range(0, rmax));
            op_ready = ($urandom_range(0, 99) < popr);
            cyc();
        end
    endtask

    task automatic set_vec(input int i, input logic wbv, input logic [AW-1:0] wrd,
                           input logic [DW-1:0] wd, input logic rdv, input logic [AW-1:0] ra,
                           input logic [AW-1:0] rb, input logic opr, input logic e_rdy,
                           input logic e_rw, input logic [3*AW-1:0] e_rs,
                           input logic [DW-1:0] e_d, input logic e_opv, input logic [DW-1:0] e_opa);
        tbl[i] = '{wbv: wbv, wrd: wrd, wd: wd, rdv: rdv, ra: ra, rb: rb, opr: opr,
                   e_rdy: e_rdy, e_wbr: 1'b1, e_rw: e_rw, e_rs: e_rs, e_d: e_d,
                   e_opv: e_opv, e_opa: e_opa};
    endtask

    initial begin
        int n;
        checks = 0; errors = 0;
        for (int i = 0; i < 16; i++) begin rbmem[i] = '0; mregs[i] = '0; end
        wq.delete(); busy = 0; starve = 0; ea = '0; eb = '0;
        rst = 1'b1; rd_valid = 0; rd_ra = '0; rd_rb = '0; op_ready = 0;
        wb_valid = 0; wb_rd = '0; wb_data = '0;

        // Write R3=BEEF, then read ra=3 rb=0.
        set_vec(0, 1, 4'd3, 16'hBEEF, 0, 4'd0, 4'd0, 0, 0, 0, 12'h000, 16'h0000, 0, 16'h0000);
`ifdef RB_BYPASS_EN
        set_vec(1, 0, 4'd0, 16'h0000, 1, 4'd3, 4'd0, 0, 1, 0, 12'h030, 16'h0000, 0, 16'h0000);
        set_vec(2, 0, 4'd0, 16'h0000, 1, 4'd3, 4'd0, 0, 0, 1, 12'h300, 16'hBEEF, 1, 16'hBEEF);
`else
        set_vec(1, 0, 4'd0, 16'h0000, 1, 4'd3, 4'd0, 0, 0, 1, 12'h300, 16'hBEEF, 0, 16'h0000);
        set_vec(2, 0, 4'd0, 16'h0000, 1, 4'd3, 4'd0, 0, 1, 0, 12'h030, 16'h0000, 0, 16'h0000);
`endif
        set_vec(3, 0, 4'd0, 16'h0000, 1, 4'd3, 4'd0, 0, 0, 0, 12'h000, 16'h0000, 1, 16'hBEEF);
        set_vec(4, 0, 4'd0, 16'h0000, 0, 4'd3, 4'd0, 1, 0, 0, 12'h000, 16'h0000, 1, 16'hBEEF);
        set_vec(5, 0, 4'd0, 16'h0000, 0, 4'd3, 4'd0, 0, 0, 0, 12'h000, 16'h0000, 0, 16'hBEEF);

        @(negedge clk);
        rd_valid = 1; wb_valid = 1;
        cyc(); cyc();
        rst = 1'b0; rd_valid = 0; wb_valid = 0;

        for (int i = 0; i < 6; i++) begin
            wb_valid = tbl[i].wbv; wb_rd = tbl[i].wrd; wb_data = tbl[i].wd;
            rd_valid = tbl[i].rdv; rd_ra = tbl[i].ra; rd_rb = tbl[i].rb;
            op_ready = tbl[i].opr;
            step(1, tbl[i]);
        end

`ifndef RB_BYPASS_EN
        // Continuous R1 writes hold off a read of R2/R4 for exactly STARVE_MAX write cycles.
        op_ready = 1; rd_valid = 0;
        wb_valid = 1; wb_rd = 4'd1; wb_data = 16'h1111;
        cyc();
        rd_valid = 1; rd_ra = 4'd2; rd_rb = 4'd4;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            wb_data = DW'($urandom);
            cyc();
            if (last_rd_ready) break;
            n++;
        end
        chk("starve_forced_after", 32'(n), 32'(SMAX));
        rd_valid = 0; wb_valid = 0;
        repeat (4) cyc();
`endif

        // Hold operands in RESP while writes keep draining.
        rd_valid = 1; rd_ra = 4'd3; rd_rb = 4'd1; op_ready = 0;
        cyc();
        rd_valid = 0; wb_valid = 1;
        for (int i = 0; i < 5; i++) begin
            wb_rd = AW'(8 + i); wb_data = DW'($urandom);
            cyc();
        end
        wb_valid = 0; op_ready = 1;
        cyc(); cyc();

        // Saturating traffic to reach a full FIFO, then random mixes.
        rand_cycles(80, 100, 100, 100, 8, 15, 3);
        rand_cycles(300, 60, 70, 60, 0, 15, 15);
        rand_cycles(300, 70, 80, 50, 0, 3, 3);

        // Reset mid-traffic for three cycles.
        wb_valid = 1; rd_valid = 1; op_ready = 0; rst = 1;
        repeat (3) cyc();
        rst = 0;
        cyc();
        rand_cycles(200, 60, 60, 70, 0, 15, 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
